// File: rtl/synapse_access_if.sv
// Requester-side bus of synapse_access_ctrl: host write port, spike read port
// and the tagged weight return.
interface synapse_access_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int WT_W   = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              spk_valid;
  logic              spk_ready;
  logic [ADDR_W-1:0] spk_addr;
  logic              wt_valid;
  logic [ADDR_W-1:0] wt_addr;
  logic [WT_W-1:0]   wt_data;

  modport slave (
    input  wr_valid, wr_addr, wr_data, spk_valid, spk_addr,
    output wr_ready, spk_ready, wt_valid, wt_addr, wt_data
  );
  modport master (
    output wr_valid, wr_addr, wr_data, spk_valid, spk_addr,
    input  wr_ready, spk_ready, wt_valid, wt_addr, wt_data
  );
endinterface

// File: rtl/synapse_access_ctrl.sv
// Arbitrates host writes and spike reads onto the single synapse port,
// sequences memory clear and returns address-tagged weights after RD_LAT.
module synapse_access_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int WT_W     = 16,
  parameter int RD_LAT   = 2,
  parameter int RD_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg_rc,
  input  logic              i_clr_req,
  output logic              o_clr_done,
  output logic              o_busy,
  synapse_access_if.slave   bus,
  output logic [ADDR_W-1:0] o_syn_iAddr,
  output logic [DATA_W-1:0] o_syn_W_DATA,
  output logic              o_syn_W_EN,
  output logic              o_syn_R_EN,
  output logic              o_syn_kill,
  input  logic [WT_W-1:0]   i_syn_weight_out
);
  localparam int BW = $clog2(RD_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(RD_BURST);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_DRAIN, S_WR_A, S_WR_B, S_CLR} state_t;

  state_t                      r_state;
  logic                        r_run, r_clr_pend;
  logic                        r_wr_ready, r_w_en, r_kill, r_clr_done, r_r_en;
  logic [BW-1:0]               r_burst;
  logic [ADDR_W-1:0]           r_iaddr;
  logic [DATA_W-1:0]           r_wdata;
  logic [RD_LAT:1]             r_vld_pipe;
  logic [RD_LAT:1][ADDR_W-1:0] r_addr_pipe;

  logic w_issue_st, w_wr_win, w_spk_ready, w_rd_acc, w_rd_issue, w_pipe_busy, w_clr;

  // r_run keeps both ready lines low until the first edge after reset
  assign w_issue_st  = r_run & ((r_state == S_IDLE) | (r_state == S_RD));
  assign w_wr_win    = w_issue_st & ~i_clr_req & bus.wr_valid &
                       (~bus.spk_valid | (r_burst == BMAX));
  assign w_spk_ready = w_issue_st & ~i_clr_req & ~w_wr_win;
  assign w_rd_acc    = w_spk_ready & bus.spk_valid;
  // address 0 is the null weight: handshaken but never issued
  assign w_rd_issue  = w_rd_acc & (|bus.spk_addr);
  assign w_pipe_busy = |r_vld_pipe;
  assign w_clr       = r_clr_pend | i_clr_req;

  assign bus.spk_ready = w_spk_ready;
  assign bus.wr_ready  = r_wr_ready;
  assign bus.wt_valid  = r_vld_pipe[RD_LAT];
  assign bus.wt_addr   = r_addr_pipe[RD_LAT];
  assign bus.wt_data   = r_vld_pipe[RD_LAT] ? i_syn_weight_out : '0;

  assign o_syn_iAddr  = w_rd_issue ? bus.spk_addr :
                        (r_state == S_WR_A) ? bus.wr_addr : r_iaddr;
  assign o_syn_W_DATA = (r_state == S_WR_A) ? bus.wr_data : r_wdata;
  assign o_syn_W_EN   = r_w_en;
  assign o_syn_kill   = r_kill;
  assign o_syn_R_EN   = r_r_en;
  assign o_clr_done   = r_clr_done;
  assign o_busy       = (r_state != S_IDLE) | w_pipe_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_run       <= 1'b0;
      r_clr_pend  <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_w_en      <= 1'b0;
      r_kill      <= 1'b0;
      r_clr_done  <= 1'b0;
      r_r_en      <= 1'b1;
      r_burst     <= '0;
      r_iaddr     <= '0;
      r_wdata     <= '0;
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
    end else begin
      r_run          <= 1'b1;
      r_r_en         <= i_cfg_rc;
      r_vld_pipe[1]  <= w_rd_issue;
      r_addr_pipe[1] <= bus.spk_addr;
      for (int i = 2; i <= RD_LAT; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_addr_pipe[i] <= r_addr_pipe[i-1];
      end
      r_clr_pend <= (r_state == S_CLR) ? 1'b0 : (r_clr_pend | i_clr_req);
      r_wr_ready <= 1'b0;
      r_w_en     <= 1'b0;
      r_kill     <= 1'b0;
      r_clr_done <= 1'b0;
      if (w_rd_issue) r_iaddr <= bus.spk_addr;
      if (w_rd_acc)
        r_burst <= !bus.wr_valid ? '0 : (r_burst == BMAX) ? r_burst : r_burst + 1'b1;
      case (r_state)
        S_IDLE, S_RD: if (w_issue_st) begin
          if (i_clr_req) begin
            if (w_pipe_busy) r_state <= S_DRAIN;
            else begin r_state <= S_CLR; r_kill <= 1'b1; end
          end else if (w_wr_win) begin
            r_burst <= '0;
            if (w_pipe_busy) r_state <= S_DRAIN;
            else begin r_state <= S_WR_A; r_wr_ready <= 1'b1; end
          end else begin
            r_state <= w_rd_acc ? S_RD : S_IDLE;
          end
        end
        S_DRAIN: if (!w_pipe_busy) begin
          if (w_clr) begin r_state <= S_CLR; r_kill <= 1'b1; end
          else begin r_state <= S_WR_A; r_wr_ready <= 1'b1; end
        end
        S_WR_A: begin
          r_iaddr <= bus.wr_addr;
          r_wdata <= bus.wr_data;
          r_w_en  <= 1'b1;
          r_state <= S_WR_B;
        end
        S_WR_B: begin
          if (w_clr) begin r_state <= S_CLR; r_kill <= 1'b1; end
          else r_state <= S_IDLE;
        end
        S_CLR: begin
          r_state    <= S_IDLE;
          r_clr_done <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/synapse_access_ctrl.md
# synapse_access_ctrl

Sequencer and arbiter in front of one `synapse` instance. It shares the synapse's single address/write port between two requesters:
- a host weight-load port, for writes;
- a spike port carrying presynaptic addresses, for reads.

It also sequences the memory clear (`kill`), tracks read latency and returns each fetched weight tagged with its address. It sits between the spike router / host config bus and the synapse, and drives all synapse inputs.

## Interface
Parameters:
- ADDR_W, 7, synapse address width
- DATA_W, 32, write data width
- WT_W, 16, weight width ({int[15:8], deci[7:0]})
- RD_LAT, 2, cycles from read issue to sampling `syn_weight_out` (≥1)
- RD_BURST, 4, maximum consecutive reads granted while a write is pending

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_rc  in  1  rich-club mode; registered, drives syn_R_EN
- clr_req  in  1  level; request memory clear
- clr_done  out  1  one-cycle pulse when clear completes
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- spk_valid  in  1  spike read request
- spk_ready  out  1  read accepted when spk_valid & spk_ready
- spk_addr  in  ADDR_W  presynaptic address
- wt_valid  out  1  weight result valid, one-cycle pulse per read
- wt_addr  out  ADDR_W  address of returned weight
- wt_data  out  WT_W  returned weight
- busy  out  1  FSM not IDLE or reads in flight
- syn_iAddr  out  ADDR_W  to synapse iAddr
- syn_W_DATA  out  DATA_W  to synapse W_DATA
- syn_W_EN  out  1  to synapse W_EN
- syn_R_EN  out  1  to synapse R_EN
- syn_kill  out  1  to synapse kill
- syn_weight_out  in  WT_W  from synapse weight_out

## Operation
FSM states:
- IDLE: no transaction in issue.
- RD: streaming reads, one per cycle.
- DRAIN: waiting for the read pipeline to empty.
- WR_A, WR_B: two-cycle write.
- CLR: kill pulse.

Priority: clear > write/read (round-robin) > idle.

Clear:
- When clr_req is sampled high, stop accepting requests; wr_ready = spk_ready = 0.
- Go to DRAIN until no reads are in flight, then CLR.
- CLR: syn_kill = 1 for exactly one cycle, then clr_done = 1 for one cycle, then IDLE.
- A clr_req still high after clr_done starts a new clear.

Reads:
- Accept in IDLE or RD: spk_ready = 1 when no clear is pending and no write has won arbitration.
- Accepted read: syn_iAddr = spk_addr, syn_W_EN = 0 in the same cycle.
- The address enters a RD_LAT-deep valid/address shift pipeline.
- At pipeline exit: wt_valid = 1, wt_addr = exit address, wt_data = syn_weight_out.
- spk_addr == 0 is accepted and discarded: no synapse access, no wt_valid, no pipeline entry. Address 0 is reserved as the null weight.

Writes:
- A pending write wins when any of these holds:
  - no read is pending;
  - RD_BURST reads have been granted consecutively while wr_valid was high;
  - the last grant was a read and no spike is valid.
- Winning write: go to DRAIN (skip it if the pipeline is empty), then WR_A.
- WR_A: wr_ready = 1 (handshake), syn_iAddr = wr_addr, syn_W_DATA = wr_data, syn_W_EN = 0.
- WR_B: same syn_iAddr/syn_W_DATA held, syn_W_EN = 1.
- Then return to IDLE. The burst counter resets on a write grant.

Idle outputs:
- syn_iAddr holds the last issued address (never forced to 0).
- syn_W_EN = 0, syn_kill = 0.

syn_R_EN = cfg_rc registered, updated every cycle.

## Timing
Reset values (rst low): all outputs as follows, FSM = IDLE, pipeline empty, burst counter 0.
- 0: wr_ready, spk_ready, wt_valid, wt_addr, wt_data, clr_done, busy, syn_iAddr, syn_W_DATA, syn_W_EN, syn_kill.
- 1: syn_R_EN. This keeps the synapse decimal memory in its capture mode during reset.

Reset mid-operation: in-flight reads are discarded with no wt_valid; a partially issued write is abandoned.

Latency and throughput:
- Read: accept at cycle t → wt_valid at t+RD_LAT.
- Read throughput: 1 per cycle.
- Write: accept (WR_A) → syn_W_EN at +1; back to IDLE at +2.
- Minimum write→read turnaround: 2 cycles.
- Read→write turnaround: RD_LAT drain cycles + 2.

Other rules:
- spk_ready and wr_ready are never both high in the same cycle.
- clr_req arriving during WR_A completes WR_B first, then clears.

## Test plan
- Reset, then spikes at addrs 5,6,7 on consecutive cycles with RD_LAT = 2 → wt_valid at cycles 2,3,4 after first accept; wt_addr 5,6,7; wt_data equals the model values.
- Write addr 9, data 32'h11223344 from idle → WR_A then WR_B; syn_W_EN high exactly one cycle with syn_iAddr = 9; wr_ready one cycle.
- spk_valid held continuously with wr_valid high → exactly RD_BURST (4) reads, DRAIN for 2 cycles, write, then reads resume. No starvation either way.
- spk_addr = 0 among 3, 0, 4 → two wt_valid pulses (3, 4) only.
- clr_req during a 3-read burst → remaining reads stall, in-flight reads return, syn_kill pulses once, clr_done one cycle later, busy low after.
- Assert rst low with 2 reads in flight → all outputs reach reset values immediately; no wt_valid after release.
